// File: rtl/fractal_dispatcher.sv
// Raster-order work dispatcher for a pool of fractal cores: issues pixel coordinates
// round-robin to idle cores and retires their iteration counts in strict raster order.
module fractal_dispatcher #(
  parameter int CORE_COUNT     = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_ITER_WIDTH = 16,
  parameter int X_SIZE         = 640,
  parameter int Y_SIZE         = 480
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [DATA_WIDTH-1:0]                cfg_x0_i,
  input  logic [DATA_WIDTH-1:0]                cfg_y0_i,
  input  logic [DATA_WIDTH-1:0]                cfg_step_i,
  input  logic [MAX_ITER_WIDTH-1:0]            cfg_max_iter_i,
  output logic [CORE_COUNT-1:0]                start_o,
  output logic [CORE_COUNT*DATA_WIDTH-1:0]     x0_o,
  output logic [CORE_COUNT*DATA_WIDTH-1:0]     y0_o,
  input  logic [CORE_COUNT*MAX_ITER_WIDTH-1:0] iter_i,
  input  logic [CORE_COUNT-1:0]                done_i,
  output logic                                 pix_valid_o,
  input  logic                                 pix_ready_i,
  output logic [7:0]                           pix_r_o,
  output logic [7:0]                           pix_g_o,
  output logic [7:0]                           pix_b_o,
  output logic                                 pix_sof_o,
  output logic                                 pix_eol_o
);

  localparam int IW = $clog2(CORE_COUNT);
  localparam int XW = $clog2(X_SIZE + 1);
  localparam int YW = $clog2(Y_SIZE + 1);

  logic [IW-1:0]                     ip_q, ip_d, rp_q, rp_d;
  logic [CORE_COUNT-1:0]             busy_q, busy_d;
  logic [CORE_COUNT-1:0]             tag_sof_q, tag_sof_d, tag_eol_q, tag_eol_d;
  logic [CORE_COUNT-1:0]             start_q, start_d, start_dly_q;
  logic [CORE_COUNT*DATA_WIDTH-1:0]  x0_q, x0_d, y0_q, y0_d;
  logic [XW-1:0]                     xi_q, xi_d;
  logic [YW-1:0]                     yi_q, yi_d;
  logic [DATA_WIDTH-1:0]             xc_q, xc_d, yc_q, yc_d;
  logic [DATA_WIDTH-1:0]             lx0_q, lx0_d, step_q, step_d;
  logic [MAX_ITER_WIDTH-1:0]         maxit_q, maxit_d;
  logic                              pv_q, pv_d, sof_q, sof_d, eol_q, eol_d;
  logic [7:0]                        r_q, r_d, g_q, g_d, b_q, b_d;

  logic                              origin, last_x, last_y, issue, retire;
  logic [DATA_WIDTH-1:0]             cur_x, cur_y, cur_step, row_x0;
  logic [CORE_COUNT-1:0]             done_ok;
  logic [MAX_ITER_WIDTH-1:0]         iter;

  always_comb begin
    ip_d      = ip_q;
    rp_d      = rp_q;
    busy_d    = busy_q;
    tag_sof_d = tag_sof_q;
    tag_eol_d = tag_eol_q;
    start_d   = '0;
    x0_d      = x0_q;
    y0_d      = y0_q;
    xi_d      = xi_q;
    yi_d      = yi_q;
    xc_d      = xc_q;
    yc_d      = yc_q;
    lx0_d     = lx0_q;
    step_d    = step_q;
    maxit_d   = maxit_q;
    pv_d      = pv_q;
    sof_d     = sof_q;
    eol_d     = eol_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;

    // Pixel (0,0) takes its origin and step straight from the config inputs,
    // which are latched in the same cycle for the rest of the frame.
    origin   = (xi_q == '0) && (yi_q == '0);
    last_x   = (xi_q == XW'(X_SIZE - 1));
    last_y   = (yi_q == YW'(Y_SIZE - 1));
    cur_x    = origin ? cfg_x0_i   : xc_q;
    cur_y    = origin ? cfg_y0_i   : yc_q;
    cur_step = origin ? cfg_step_i : step_q;
    row_x0   = origin ? cfg_x0_i   : lx0_q;

    // A core's done level is stale during its start pulse and the cycle after.
    done_ok  = done_i & ~start_q & ~start_dly_q;
    issue    = ~busy_q[ip_q];
    retire   = busy_q[rp_q] & done_ok[rp_q] & (~pv_q | pix_ready_i);
    iter     = iter_i[rp_q*MAX_ITER_WIDTH +: MAX_ITER_WIDTH];

    if (issue) begin
      if (origin) begin
        lx0_d   = cfg_x0_i;
        step_d  = cfg_step_i;
        maxit_d = cfg_max_iter_i;
      end
      start_d[ip_q]                         = 1'b1;
      x0_d[ip_q*DATA_WIDTH +: DATA_WIDTH]   = cur_x;
      y0_d[ip_q*DATA_WIDTH +: DATA_WIDTH]   = cur_y;
      busy_d[ip_q]                          = 1'b1;
      tag_sof_d[ip_q]                       = origin;
      tag_eol_d[ip_q]                       = last_x;
      ip_d = (ip_q == IW'(CORE_COUNT - 1)) ? '0 : ip_q + 1'b1;
      if (last_x) begin
        xi_d = '0;
        if (last_y) begin
          yi_d = '0;
        end else begin
          yi_d = yi_q + 1'b1;
          xc_d = row_x0;
          yc_d = cur_y + cur_step;
        end
      end else begin
        xi_d = xi_q + 1'b1;
        xc_d = cur_x + cur_step;
        yc_d = cur_y;
      end
    end

    if (retire) begin
      pv_d         = 1'b1;
      sof_d        = tag_sof_q[rp_q];
      eol_d        = tag_eol_q[rp_q];
      busy_d[rp_q] = 1'b0;
      rp_d = (rp_q == IW'(CORE_COUNT - 1)) ? '0 : rp_q + 1'b1;
      if (iter >= maxit_q) begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
      end else begin
        r_d = iter[7:0];
        g_d = {iter[6:0], 1'b0};
        b_d = ~iter[7:0];
      end
    end else if (pix_ready_i) begin
      pv_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ip_q        <= '0;
      rp_q        <= '0;
      busy_q      <= '0;
      tag_sof_q   <= '0;
      tag_eol_q   <= '0;
      start_q     <= '0;
      start_dly_q <= '0;
      x0_q        <= '0;
      y0_q        <= '0;
      xi_q        <= '0;
      yi_q        <= '0;
      xc_q        <= '0;
      yc_q        <= '0;
      lx0_q       <= '0;
      step_q      <= '0;
      maxit_q     <= '0;
      pv_q        <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
    end else begin
      ip_q        <= ip_d;
      rp_q        <= rp_d;
      busy_q      <= busy_d;
      tag_sof_q   <= tag_sof_d;
      tag_eol_q   <= tag_eol_d;
      start_q     <= start_d;
      start_dly_q <= start_q;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      xi_q        <= xi_d;
      yi_q        <= yi_d;
      xc_q        <= xc_d;
      yc_q        <= yc_d;
      lx0_q       <= lx0_d;
      step_q      <= step_d;
      maxit_q     <= maxit_d;
      pv_q        <= pv_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
    end
  end

  assign start_o     = start_q;
  assign x0_o        = x0_q;
  assign y0_o        = y0_q;
  assign pix_valid_o = pv_q;
  assign pix_sof_o   = sof_q;
  assign pix_eol_o   = eol_q;
  assign pix_r_o     = r_q;
  assign pix_g_o     = g_q;
  assign pix_b_o     = b_q;

endmodule

// File: tb/tb_fractal_dispatcher.sv
// Bench for fractal_dispatcher: emulated cores with programmable latency, a raster
// reference model for issue coordinates and retired pixels, plus directed sequences.
module tb_fractal_dispatcher;

  localparam int unsigned CC = 3;
  localparam int unsigned XS = 4;
  localparam int unsigned YS = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       cfg_x0, cfg_y0, cfg_step;
  logic [15:0]       cfg_maxit;
  logic [CC-1:0]     start;
  logic [CC*32-1:0]  x0o, y0o;
  logic [CC*16-1:0]  iter_bus;
  logic [CC-1:0]     done_bus;
  logic              pv, ready, sof, eol;
  logic [7:0]        r, g, b;

  always #5 clk = ~clk;

  fractal_dispatcher #(
    .CORE_COUNT(CC), .DATA_WIDTH(32), .MAX_ITER_WIDTH(16), .X_SIZE(XS), .Y_SIZE(YS)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_x0_i(cfg_x0), .cfg_y0_i(cfg_y0), .cfg_step_i(cfg_step), .cfg_max_iter_i(cfg_maxit),
    .start_o(start), .x0_o(x0o), .y0_o(y0o), .iter_i(iter_bus), .done_i(done_bus),
    .pix_valid_o(pv), .pix_ready_i(ready),
    .pix_r_o(r), .pix_g_o(g), .pix_b_o(b), .pix_sof_o(sof), .pix_eol_o(eol)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] hash(input logic [31:0] x, input logic [31:0] y);
    return x[31:16] ^ y[23:8];
  endfunction

  function automatic logic [23:0] colour(input int unsigned it, input int unsigned mx);
    if (it >= mx) return 24'h0;
    return {8'(it % 256), 8'((it * 2) % 256), 8'(255 - (it % 256))};
  endfunction

  // ---------------- emulated cores ----------------
  int          lat_mode;
  int          lat_fix [CC];
  logic        ovr_en;
  logic [15:0] ovr_iter;
  logic [15:0] core_iter [CC];
  logic [15:0] job_iter  [CC];
  int          cnt       [CC];

  always @(posedge clk) begin
    for (int k = 0; k < int'(CC); k++) begin
      if (rst) begin
        done_bus[k]  <= 1'b0;
        cnt[k]       <= 0;
        core_iter[k] <= '0;
      end else if (start[k]) begin
        job_iter[k] <= ovr_en ? ovr_iter : hash(x0o[k*32 +: 32], y0o[k*32 +: 32]);
        cnt[k]      <= (lat_mode != 0 ? int'($urandom_range(12, 3)) : lat_fix[k]) - 1;
      end else if (cnt[k] > 0) begin
        // done stays at its old level for one cycle after the start pulse
        if (cnt[k] > 1) done_bus[k] <= 1'b0;
        if (cnt[k] == 1) begin
          done_bus[k]  <= 1'b1;
          core_iter[k] <= job_iter[k];
        end
        cnt[k] <= cnt[k] - 1;
      end
    end
  end

  always_comb begin
    iter_bus = '0;
    for (int k = 0; k < int'(CC); k++) iter_bus[k*16 +: 16] = core_iter[k];
  end

  // ---------------- reference model / monitor ----------------
  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        sof;
    logic        eol;
    logic [15:0] maxit;
  } exp_t;

  exp_t        q [$];
  int unsigned iss_n, xfer_n;
  logic [31:0] snap_x0, snap_y0, snap_step, fx0, fy0, fstep;
  logic [15:0] snap_max, fmax;
  logic [31:0] iss_x_act [64];
  logic        hold;
  logic [27:0] prev_out;

  always @(posedge clk) begin
    snap_x0   <= cfg_x0;
    snap_y0   <= cfg_y0;
    snap_step <= cfg_step;
    snap_max  <= cfg_maxit;
  end

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      iss_n  = 0;
      xfer_n = 0;
      hold   = 1'b0;
    end else begin
      if (start != '0) begin
        int unsigned k, p;
        exp_t e;
        k = 0;
        for (int j = 0; j < int'(CC); j++) if (start[j]) k = j;
        chk("one_start", 64'($countones(start)), 64'd1);
        chk("issue_core", 64'(k), 64'(iss_n % CC));
        p = iss_n % (XS * YS);
        if (p == 0) begin
          fx0 = snap_x0; fy0 = snap_y0; fstep = snap_step; fmax = snap_max;
        end
        e.x     = fx0 + 32'(p % XS) * fstep;
        e.y     = fy0 + 32'(p / XS) * fstep;
        e.sof   = (p == 0);
        e.eol   = ((p % XS) == XS - 1);
        e.maxit = fmax;
        chk("issue_x", 64'(x0o[k*32 +: 32]), 64'(e.x));
        chk("issue_y", 64'(y0o[k*32 +: 32]), 64'(e.y));
        if (iss_n < 64) iss_x_act[iss_n] = x0o[k*32 +: 32];
        q.push_back(e);
        iss_n++;
      end
      if (hold) begin
        chk("hold_valid", 64'(pv), 64'd1);
        chk("hold_data", 64'({r, g, b, sof, eol}), 64'(prev_out));
      end
      if (pv && ready) begin
        if (q.size() == 0) begin
          chk("xfer_unexpected", 64'd1, 64'd0);
        end else begin
          exp_t e;
          logic [15:0] it;
          e  = q.pop_front();
          it = ovr_en ? ovr_iter : hash(e.x, e.y);
          chk("pix_rgb", 64'({r, g, b}), 64'(colour(it, e.maxit)));
          chk("pix_sof", 64'(sof), 64'(e.sof));
          chk("pix_eol", 64'(eol), 64'(e.eol));
        end
        xfer_n++;
      end
      chk("in_flight_bound", 64'(iss_n - xfer_n <= CC + 1), 64'd1);
      hold     = pv && !ready;
      prev_out = {r, g, b, sof, eol};
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] it;
    logic [15:0] mx;
    logic [23:0] rgb;
  } cvec_t;

  cvec_t       tbl [8];
  logic [31:0] xseq [4];
  logic        a_sof [8];
  logic        a_eol [8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int got, cyc;
    int unsigned n10, n20;

    tbl[0] = '{16'd100,   16'd100,   24'h000000};
    tbl[1] = '{16'h0013,  16'd100,   24'h1326EC};
    tbl[2] = '{16'd99,    16'd100,   24'h63C69C};
    tbl[3] = '{16'd0,     16'd100,   24'h0000FF};
    tbl[4] = '{16'd101,   16'd100,   24'h000000};
    tbl[5] = '{16'h01FF,  16'hFFFF,  24'hFFFE00};
    tbl[6] = '{16'hFFFF,  16'hFFFF,  24'h000000};
    tbl[7] = '{16'h0080,  16'h0100,  24'h80007F};
    xseq[0] = 32'hFE000000; xseq[1] = 32'hFE100000;
    xseq[2] = 32'hFE200000; xseq[3] = 32'hFE300000;

    rst = 1'b1; ready = 1'b1; ovr_en = 1'b0; ovr_iter = '0; lat_mode = 0;
    for (int k = 0; k < int'(CC); k++) lat_fix[k] = 5;
    cfg_x0 = 32'hFE000000; cfg_y0 = 32'h01000000; cfg_step = 32'h00100000; cfg_maxit = 16'hFFFF;
    repeat (3) tick();

    chk("rst_start", 64'(start), 64'd0);
    chk("rst_valid", 64'(pv), 64'd0);
    chk("rst_sof_eol", 64'({sof, eol}), 64'd0);
    chk("rst_rgb", 64'({r, g, b}), 64'd0);
    chk("rst_xy_zero", 64'((x0o == '0) && (y0o == '0)), 64'd1);

    // Basic 4x2 frame, fixed 5-cycle cores
    rst = 1'b0;
    tick();
    chk("first_start", 64'(start), 64'd1);
    chk("first_x0", 64'(x0o[31:0]), 64'hFE000000);
    got = 0;
    for (cyc = 0; cyc < 200 && got < 8; cyc++) begin
      if (pv && ready) begin
        a_sof[got] = sof;
        a_eol[got] = eol;
        got++;
      end
      tick();
    end
    chk("frame_count", 64'(got), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("frame_sof", 64'(a_sof[i]), 64'(i == 0));
      chk("frame_eol", 64'(a_eol[i]), 64'(i == 3 || i == 7));
      chk("frame_x0_seq", 64'(iss_x_act[i]), 64'(xseq[i % 4]));
    end

    // Reverse completion order
    rst = 1'b1; tick(); tick();
    lat_fix[0] = 14; lat_fix[1] = 9; lat_fix[2] = 4;
    rst = 1'b0; tick();
    for (cyc = 0; cyc < 100; cyc++) begin
      if (pv) break;
      tick();
    end
    chk("rev_first_valid_waits_core0", 64'(cyc >= 13 && cyc < 100), 64'd1);
    repeat (100) tick();

    // Back-pressure for 20 cycles
    for (int k = 0; k < int'(CC); k++) lat_fix[k] = 5;
    repeat (20) tick();
    ready = 1'b0;
    n10 = 0; n20 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 9) n10 = iss_n;
    end
    n20 = iss_n;
    chk("bp_valid_held", 64'(pv), 64'd1);
    chk("bp_no_new_start", 64'(n20 - n10), 64'd0);
    chk("bp_in_flight", 64'(iss_n - xfer_n), 64'(CC + 1));

    // Reset with all cores busy and an undrained pixel
    rst = 1'b1;
    cfg_x0 = 32'h12345678; cfg_y0 = 32'h0ABCDEF0;
    tick();
    chk("mid_rst_start", 64'(start), 64'd0);
    chk("mid_rst_valid", 64'(pv), 64'd0);
    chk("mid_rst_sof_eol", 64'({sof, eol}), 64'd0);
    chk("mid_rst_rgb", 64'({r, g, b}), 64'd0);
    chk("mid_rst_xy_zero", 64'((x0o == '0) && (y0o == '0)), 64'd1);
    rst = 1'b0; ready = 1'b1;
    tick();
    chk("post_rst_start", 64'(start), 64'd1);
    chk("post_rst_x0", 64'(x0o[31:0]), 64'h12345678);
    chk("post_rst_y0", 64'(y0o[31:0]), 64'h0ABCDEF0);
    repeat (40) tick();

    // Step change mid-frame applies from the next frame
    rst = 1'b1;
    cfg_x0 = 32'h0; cfg_y0 = 32'h0; cfg_step = 32'h00010000;
    tick(); tick();
    rst = 1'b0;
    for (cyc = 0; cyc < 100 && iss_n < 3; cyc++) tick();
    cfg_step = 32'h00030000; cfg_x0 = 32'h00500000;
    for (cyc = 0; cyc < 200 && iss_n < 12; cyc++) tick();
    chk("step_reached", 64'(iss_n >= 12), 64'd1);
    chk("step_old_p3", 64'(iss_x_act[3]), 64'h00030000);
    chk("step_old_p7", 64'(iss_x_act[7]), 64'h00030000);
    chk("step_new_p8", 64'(iss_x_act[8]), 64'h00500000);
    chk("step_new_p9", 64'(iss_x_act[9]), 64'h00530000);
    chk("step_new_p11", 64'(iss_x_act[11]), 64'h00590000);

    // Colour map vectors
    for (int i = 0; i < 8; i++) begin
      rst = 1'b1;
      ovr_en = 1'b1; ovr_iter = tbl[i].it; cfg_maxit = tbl[i].mx;
      tick(); tick();
      rst = 1'b0;
      for (cyc = 0; cyc < 50; cyc++) begin
        if (pv) break;
        tick();
      end
      chk("cmap_valid", 64'(pv), 64'd1);
      chk("cmap_rgb", 64'({r, g, b}), 64'(tbl[i].rgb));
    end

    // Randomised run: random latencies, back-pressure and config changes
    rst = 1'b1;
    ovr_en = 1'b0; lat_mode = 1; cfg_maxit = 16'h8000;
    cfg_x0 = $urandom; cfg_y0 = $urandom; cfg_step = $urandom;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      ready = ($urandom_range(99, 0) < 70);
      if ($urandom_range(149, 0) == 0) begin
        cfg_x0 = $urandom; cfg_y0 = $urandom; cfg_step = $urandom;
      end
      tick();
    end
    ready = 1'b1;
    repeat (60) tick();
    chk("random_progress", 64'(xfer_n > 100), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
